sparse_stream_loader: RTL

- Upstream feeder for the sparse-matrix word memory.
- Accepts a length-prefixed byte stream over a valid/ready handshake and drives the memory's write port (wen, writePtr, inData).
- The memory shifts each byte into the addressed entry. The loader therefore holds the pointer for BYTES_PER_WORD consecutive bytes, then advances.
- Reports completion and length errors to the control FSM.

---
 rtl/sparse_stream_loader_pkg.sv | 21 ++
 rtl/sparse_stream_loader.sv | 133 +++++++++++++
 2 files changed

// File: rtl/sparse_stream_loader_pkg.sv
// sparse_pkg: types and widths shared by the sparse-matrix memory loader.
//   loader_state_t : loader FSM states
//   WORD_W         : width of one memory entry
//   BYTE_W         : width of one stream byte
//   PTR_W          : width of the memory write pointer and the header count
package sparse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    LOAD,
    DONE,
    ERR
  } loader_state_t;

  localparam int WORD_W = 64;
  localparam int BYTE_W = 8;
  localparam int PTR_W  = 16;

endpackage

// File: rtl/sparse_stream_loader.sv
// sparse_stream_loader: takes a length-prefixed byte stream (16-bit big-endian
// word count, then count*BYTES_PER_WORD bytes) over valid/ready and drives the
// write port of the sparse-matrix word memory. The memory shifts each byte into
// the addressed entry, so the pointer is held for BYTES_PER_WORD bytes.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   start             : pulse; begins a load from IDLE, DONE or ERR
//   in_valid, in_data : stream byte, accepted when in_valid && in_ready
//   in_ready          : high in HDR_HI, HDR_LO and LOAD
//   mem_wen           : write strobe, one cycle after each accepted data byte
//   mem_write_ptr     : entry index of the current write (held between writes)
//   mem_in_data       : byte to shift into the entry
//   word_count        : header value of the current load
//   done, error       : completion / header-count-too-large levels
module sparse_stream_loader
  import sparse_pkg::*;
#(
  parameter int DEPTH          = 64,
  parameter int BYTES_PER_WORD = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_wen,
  output logic [PTR_W-1:0]  mem_write_ptr,
  output logic [BYTE_W-1:0] mem_in_data,
  output logic [PTR_W-1:0]  word_count,
  output logic              done,
  output logic              error
);

  localparam int              IDX_W    = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES_PER_WORD - 1);

  loader_state_t     state_q, state_d;
  logic [PTR_W-1:0]  wc_q, wc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PTR_W-1:0]  widx_q, widx_d;
  logic              wen_q, wen_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [BYTE_W-1:0] dat_q, dat_d;

  logic              accept;
  logic [PTR_W-1:0]  hdr_cnt;

  assign in_ready = (state_q == HDR_HI) || (state_q == HDR_LO) || (state_q == LOAD);
  assign accept   = in_valid && in_ready;
  // Full header count as it will be once the low byte lands.
  assign hdr_cnt  = {wc_q[PTR_W-1:BYTE_W], in_data};

  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    idx_d   = idx_q;
    widx_d  = widx_q;
    wen_d   = 1'b0;
    ptr_d   = ptr_q;
    dat_d   = dat_q;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) state_d = HDR_HI;
      end
      HDR_HI: begin
        if (accept) begin
          wc_d    = {in_data, wc_q[BYTE_W-1:0]};
          state_d = HDR_LO;
        end
      end
      HDR_LO: begin
        if (accept) begin
          wc_d = hdr_cnt;
          if (hdr_cnt == '0) begin
            state_d = DONE;
          end else if (hdr_cnt > PTR_W'(DEPTH)) begin
            state_d = ERR;
          end else begin
            state_d = LOAD;
            ptr_d   = '0;
            idx_d   = '0;
            widx_d  = '0;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          wen_d = 1'b1;
          dat_d = in_data;
          ptr_d = widx_q;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            // Last byte of the last word: leave LOAD so in_ready drops at once.
            if (widx_q == wc_q - 16'd1) state_d = DONE;
            else                         widx_d  = widx_q + 16'd1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wc_q    <= '0;
      idx_q   <= '0;
      widx_q  <= '0;
      wen_q   <= 1'b0;
      ptr_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      idx_q   <= idx_d;
      widx_q  <= widx_d;
      wen_q   <= wen_d;
      ptr_q   <= ptr_d;
      dat_q   <= dat_d;
    end
  end

  assign mem_wen       = wen_q;
  assign mem_write_ptr = ptr_q;
  assign mem_in_data   = dat_q;
  assign word_count    = wc_q;
  assign done          = (state_q == DONE);
  assign error         = (state_q == ERR);

endmodule
